// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan capture block.
// Holds the active-low segment table, slot geometry and FSM states.
package seg_scan_pkg;

  localparam int DIGITS   = 8;
  localparam int NIBBLE_W = 4;

  // Active-low a..g patterns for hex digits 0..F (dp excluded).
  localparam logic [6:0] SEG_ACTIVE_LOW [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg_scan_capture_seg7_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Ports: i_seg (a..g, active low) -> o_valid, o_nibble.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0]          i_seg,
  output logic                o_valid,
  output logic [NIBBLE_W-1:0] o_nibble
);

  always_comb begin
    o_valid  = 1'b0;
    o_nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG_ACTIVE_LOW[i]) begin
        o_valid  = 1'b1;
        o_nibble = NIBBLE_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of an 8-digit scanned seven-segment bus: synchronizes,
// debounces, decodes each digit and reassembles a 32-bit word.
// Ports: clk, rst_n (async, active low), which_in[2:0], seg_in[7:0]
//   (active low a..g,dp) -> data_out[31:0], frame_valid, digit_err,
//   slot_mask[7:0]. Optional `SEG_CAPTURE_ERR_COUNT_EN adds err_count[7:0].
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  which_in,
  input  logic [7:0]  seg_in,
  output logic [31:0] data_out,
  output logic        frame_valid,
  output logic        digit_err,
`ifdef SEG_CAPTURE_ERR_COUNT_EN
  output logic [7:0]  err_count,
`endif
  output logic [7:0]  slot_mask
);

  logic [10:0]         r_sync [SYNC_STAGES];
  logic [10:0]         r_prev;
  logic [7:0]          r_cnt;
  state_t              r_state;
  logic [NIBBLE_W-1:0] r_stage [DIGITS];
  logic [DIGITS-1:0]   r_mask;
  logic [31:0]         r_data;
  logic                r_frame_valid;
  logic                r_digit_err;

  logic [10:0]         w_sample;
  logic [2:0]          w_which;
  logic [7:0]          w_seg;
  logic                w_unused_dp;
  logic                w_dec_ok;
  logic [NIBBLE_W-1:0] w_dec_nib;
  logic [7:0]          w_cnt_inc;
  logic                w_same;
  logic                w_accept;
  logic                w_good;
  logic                w_bad;
  logic                w_full;
  logic [DIGITS-1:0]   w_mask_base;
  logic [31:0]         w_packed;

  assign w_sample    = r_sync[SYNC_STAGES-1];
  assign w_which     = w_sample[10:8];
  assign w_seg       = w_sample[7:0];
  assign w_unused_dp = w_seg[0];

  seg7_decode u_dec (
    .i_seg    (w_seg[7:1]),
    .o_valid  (w_dec_ok),
    .o_nibble (w_dec_nib)
  );

  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_same    = (w_sample == r_prev);
  // Acceptance fires once, on the cycle the run length hits the target.
  assign w_accept  = (r_state == SETTLE) && w_same &&
                     (w_cnt_inc == 8'(STABLE_CYCLES));
  assign w_good    = w_accept && w_dec_ok;
  assign w_bad     = w_accept && !w_dec_ok;
  assign w_full    = (r_mask == '1);
  // Mask clear happens first so a same-cycle capture opens the new frame.
  assign w_mask_base = w_full ? '0 : r_mask;

  always_comb begin
    w_packed = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_packed[31-4*k -: 4] = r_stage[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= {which_in, seg_in};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
      r_cnt   <= '0;
      r_prev  <= '0;
    end else begin
      r_prev <= w_sample;
      unique case (r_state)
        WAIT: begin
          r_state <= SETTLE;
          r_cnt   <= 8'd1;
        end
        SETTLE: begin
          if (!w_same) begin
            r_cnt <= 8'd1;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_accept) r_state <= HOLD;
          end
        end
        HOLD: begin
          if (!w_same) begin
            r_state <= SETTLE;
            r_cnt   <= 8'd1;
          end
        end
        default: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIGITS; k++) begin
        r_stage[k] <= '0;
      end
      r_mask        <= '0;
      r_data        <= '0;
      r_frame_valid <= 1'b0;
      r_digit_err   <= 1'b0;
    end else begin
      r_frame_valid <= w_full;
      r_digit_err   <= w_bad;
      if (w_full) r_data <= w_packed;
      if (w_good) r_stage[w_which] <= w_dec_nib;
      r_mask <= w_mask_base |
                (w_good ? (DIGITS'(1) << w_which) : '0);
    end
  end

`ifdef SEG_CAPTURE_ERR_COUNT_EN
  logic [7:0] r_err_cnt;
  logic       r_frame_err;

  // A frame begins with the first good capture into an empty mask;
  // the count only clears if that frame saw no bad pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_bad) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        r_frame_err <= 1'b1;
      end else if (w_full && !r_frame_err) begin
        r_err_cnt <= '0;
      end
      if (w_good && (w_mask_base == '0)) r_frame_err <= 1'b0;
    end
  end

  assign err_count = r_err_cnt;
`endif

  assign data_out    = r_data;
  assign frame_valid = r_frame_valid;
  assign digit_err   = r_digit_err;
  assign slot_mask   = r_mask;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: random and directed scans.
// Expected frames/errors are queued at drive time and popped on output.
module tb_seg_scan_capture;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  which_in = '0;
  logic [7:0]  seg_in = 8'hFF;
  logic [31:0] data_out;
  logic        frame_valid;
  logic        digit_err;
  logic [7:0]  slot_mask;
`ifdef SEG_CAPTURE_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  seg_scan_capture #(
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .which_in    (which_in),
    .seg_in      (seg_in),
    .data_out    (data_out),
    .frame_valid (frame_valid),
    .digit_err   (digit_err),
`ifdef SEG_CAPTURE_ERR_COUNT_EN
    .err_count   (err_count),
`endif
    .slot_mask   (slot_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_frame;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];

  logic [6:0] TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic [3:0]  m_nib [8];
  logic [7:0]  m_mask;
  logic [10:0] m_prev;
  logic [31:0] m_last;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [7:0] s);
    for (int i = 0; i < 16; i++)
      if (s[7:1] == TBL[i]) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  function automatic logic [31:0] ref_pack();
    logic [31:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p[31-4*k -: 4] = m_nib[k];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_nib[k] = '0;
    m_mask = '0;
    m_prev = '0;
    m_last = '0;
  endtask

  // A held pattern is taken once if it stays put for STABLE cycles.
  task automatic seg_drive(input logic [2:0] w, input logic [7:0] s,
                           input int len);
    logic [4:0] d;
    ev_t ev;
    which_in = w;
    seg_in   = s;
    if (len >= STABLE) begin
      d = ref_dec(s);
      if (d[4]) begin
        m_nib[w]  = d[3:0];
        m_mask[w] = 1'b1;
        if (m_mask == 8'hFF) begin
          ev.is_frame = 1'b1;
          ev.data     = ref_pack();
          m_last      = ev.data;
          exp_q.push_back(ev);
          m_mask = '0;
        end
      end else begin
        ev.is_frame = 1'b0;
        ev.data     = '0;
        exp_q.push_back(ev);
      end
    end
    m_prev = {w, s};
    repeat (len) @(negedge clk);
  endtask

  task automatic scan_word(input logic [31:0] word, input int len);
    logic [3:0] n;
    for (int k = 0; k < 8; k++) begin
      n = word[31-4*k -: 4];
      seg_drive(3'(k), {TBL[n], 1'b1}, len);
    end
  endtask

  task automatic drain(input string name);
    repeat (SYNC + STABLE + 4) @(negedge clk);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk({name, "_slot_mask"}, {24'd0, slot_mask}, {24'd0, m_mask});
    chk({name, "_data_out"}, data_out, m_last);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_slot_mask", {24'd0, slot_mask}, 32'd0);
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_digit_err", {31'd0, digit_err}, 32'd0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (rst_n) begin
      if (frame_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: got data %h expected none",
                   data_out);
        end else begin
          ev = exp_q.pop_front();
          if (!ev.is_frame || data_out !== ev.data) begin
            errors++;
            $display("FAIL frame: got data %h expected frame=%0d data %h",
                     data_out, ev.is_frame, ev.data);
          end
        end
      end
      if (digit_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_digit_err: got pulse expected none");
        end else begin
          ev = exp_q.pop_front();
          if (ev.is_frame) begin
            errors++;
            $display("FAIL digit_err: got error expected frame %h",
                     ev.data);
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] w;
    logic [7:0] s;
    int         len;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_data_out", data_out, 32'd0);
    chk("init_slot_mask", {24'd0, slot_mask}, 32'd0);
    chk("init_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("init_digit_err", {31'd0, digit_err}, 32'd0);
    rst_n = 1'b1;

    seg_drive(3'd3, {TBL[2], 1'b1}, 100);
    drain("hold");
    chk("hold_mask_08", {24'd0, slot_mask}, 32'h08);

    seg_drive(3'd3, {TBL[7], 1'b1}, 10);
    seg_drive(3'd3, 8'b1001_1111, 3);
    seg_drive(3'd3, {TBL[7], 1'b1}, 10);
    drain("glitch");

    seg_drive(3'd5, 8'hFF, 20);
    drain("blank");
    chk("blank_mask5", {31'd0, slot_mask[5]}, 32'd0);

    scan_word(32'h1234_ABCD, 6);
    scan_word(32'h1234_ABCD, 6);
    drain("scan");
    chk("scan_data", data_out, 32'h1234ABCD);

    for (int k = 0; k < 6; k++) seg_drive(3'(k), {TBL[9], 1'b0}, 6);
    drain("partial");
    do_reset();
    scan_word(32'hDEAD_BEEF, 6);
    drain("after_rst");
    chk("after_rst_data", data_out, 32'hDEADBEEF);

    for (int i = 0; i < 600; i++) begin
      do begin
        w = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 99) < 85)
          s = {TBL[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
        else
          s = 8'($urandom_range(0, 255));
      end while ({w, s} == m_prev);
      if (i == 599 || $urandom_range(0, 99) >= 30)
        len = $urandom_range(STABLE, 9);
      else
        len = $urandom_range(1, STABLE - 1);
      seg_drive(w, s, len);
    end
    drain("random");

`ifdef SEG_CAPTURE_ERR_COUNT_EN
    do_reset();
    chk("errcnt_rst", {24'd0, err_count}, 32'd0);
    for (int i = 0; i < 300; i++) seg_drive(3'(i % 8), 8'hFF, 5);
    drain("errs");
    chk("errcnt_sat", {24'd0, err_count}, 32'hFF);
    scan_word(32'h0000_0000, 6);
    drain("clean");
    chk("errcnt_clear", {24'd0, err_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
